// File: rtl/brick_pixel_plotter.sv
// Rasterises one brick per draw request into row-major single-pixel VGA writes,
// clipping off-screen pixels while keeping the request length fixed.
module brick_pixel_plotter #(
   parameter int BRICK_W  = 10,
   parameter int BRICK_H  = 5,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       draw,
   input  logic [9:0] x_in,
   input  logic [9:0] y_in,
   input  logic [2:0] colour_in,
   input  logic       erase,
   output logic       busy,
   output logic       done,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot
);

   localparam int DXW = (BRICK_W > 1) ? $clog2(BRICK_W) : 1;
   localparam int DYW = (BRICK_H > 1) ? $clog2(BRICK_H) : 1;
   localparam logic [DXW-1:0] DX_LAST = DXW'(BRICK_W - 1);
   localparam logic [DYW-1:0] DY_LAST = DYW'(BRICK_H - 1);
   localparam logic [10:0] SCR_W = 11'(SCREEN_W);
   localparam logic [10:0] SCR_H = 11'(SCREEN_H);

   typedef enum logic [1:0] {IDLE, PLOT, DONE} state_t;

   state_t           state_q, state_d;
   logic [9:0]       x_base_q, x_base_d;
   logic [9:0]       y_base_q, y_base_d;
   logic [2:0]       colour_q, colour_d;
   logic [DXW-1:0]   dx_q, dx_d;
   logic [DYW-1:0]   dy_q, dy_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [7:0]       vga_x_q, vga_x_d;
   logic [6:0]       vga_y_q, vga_y_d;
   logic [2:0]       vga_colour_q, vga_colour_d;
   logic             vga_plot_q, vga_plot_d;

   logic [10:0]      px, py;
   logic             last_col, last_row;

   // 11-bit sums so origins near the 10-bit limit never wrap back on screen
   assign px       = {1'b0, x_base_q} + 11'(dx_q);
   assign py       = {1'b0, y_base_q} + 11'(dy_q);
   assign last_col = (dx_q == DX_LAST);
   assign last_row = (dy_q == DY_LAST);

   always_comb begin
      state_d      = state_q;
      x_base_d     = x_base_q;
      y_base_d     = y_base_q;
      colour_d     = colour_q;
      dx_d         = dx_q;
      dy_d         = dy_q;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      vga_x_d      = 8'd0;
      vga_y_d      = 7'd0;
      vga_colour_d = 3'd0;
      vga_plot_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (draw) begin
               x_base_d = x_in;
               y_base_d = y_in;
               colour_d = erase ? 3'b000 : colour_in;
               dx_d     = '0;
               dy_d     = '0;
               state_d  = PLOT;
            end
         end
         PLOT: begin
            busy_d       = 1'b1;
            vga_x_d      = px[7:0];
            vga_y_d      = py[6:0];
            vga_colour_d = colour_q;
            vga_plot_d   = (px < SCR_W) && (py < SCR_H);
            if (last_col) begin
               dx_d = '0;
               if (last_row) begin
                  dy_d    = '0;
                  state_d = DONE;
               end else begin
                  dy_d = dy_q + DYW'(1);
               end
            end else begin
               dx_d = dx_q + DXW'(1);
            end
         end
         DONE: begin
            busy_d  = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         x_base_q     <= '0;
         y_base_q     <= '0;
         colour_q     <= '0;
         dx_q         <= '0;
         dy_q         <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         vga_plot_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_base_q     <= x_base_d;
         y_base_q     <= y_base_d;
         colour_q     <= colour_d;
         dx_q         <= dx_d;
         dy_q         <= dy_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_colour_q <= vga_colour_d;
         vga_plot_q   <= vga_plot_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_brick_pixel_plotter.sv
// Self-checking bench for brick_pixel_plotter: directed bricks from the test plan
// plus random origins, each compared against a row-major pixel-list model.
module tb_brick_pixel_plotter;

   localparam int BW = 10;
   localparam int BH = 5;
   localparam int SW = 160;
   localparam int SH = 120;

   logic       clk;
   logic       resetn;
   logic       draw;
   logic [9:0] x_in;
   logic [9:0] y_in;
   logic [2:0] colour_in;
   logic       erase;
   logic       busy;
   logic       done;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;

   int compared;
   int mismatched;

   brick_pixel_plotter #(
      .BRICK_W(BW), .BRICK_H(BH), .SCREEN_W(SW), .SCREEN_H(SH)
   ) dut (
      .clk(clk), .resetn(resetn), .draw(draw), .x_in(x_in), .y_in(y_in),
      .colour_in(colour_in), .erase(erase), .busy(busy), .done(done),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so a broken design can never stall the run
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it and reports tag/observed/expected on a miss
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Every output should be at its reset/idle value
   task automatic checkIdle(input string tag);
      checkOutput({tag, "_busy"},   32'(busy),       32'd0);
      checkOutput({tag, "_done"},   32'(done),       32'd0);
      checkOutput({tag, "_plot"},   32'(vga_plot),   32'd0);
      checkOutput({tag, "_x"},      32'(vga_x),      32'd0);
      checkOutput({tag, "_y"},      32'(vga_y),      32'd0);
      checkOutput({tag, "_colour"}, 32'(vga_colour), 32'd0);
   endtask

   // Presents a request for one edge; unless held, draw drops and the
   // request inputs are scrambled to prove the latched copies are used
   task automatic applyStimulus(input int ox, input int oy, input logic [2:0] col,
                                input logic er, input bit hold);
      x_in      = 10'(ox);
      y_in      = 10'(oy);
      colour_in = col;
      erase     = er;
      draw      = 1'b1;
      @(posedge clk); #1;
      if (!hold) begin
         draw      = 1'b0;
         x_in      = 10'($urandom);
         y_in      = 10'($urandom);
         colour_in = 3'($urandom);
         erase     = 1'($urandom);
      end
   endtask

   // Walks the expected pixel list k = 0..BW*BH-1 after the accepting edge,
   // then the done cycle and the return to idle. ignore_at pulses a stray draw;
   // reset_at asserts resetn low in place of that pixel's edge.
   task automatic checkBrick(input int ox, input int oy, input logic [2:0] col_exp,
                             input int ignore_at, input int reset_at);
      int ex, ey;
      bit ep;
      for (int k = 0; k < BW * BH; k++) begin
         if (k == reset_at) begin
            resetn = 1'b0;
            @(posedge clk); #1;
            checkIdle("abort");
            resetn = 1'b1;
            for (int c = 0; c < 3; c++) begin
               @(posedge clk); #1;
               checkOutput("post_abort_busy", 32'(busy), 32'd0);
               checkOutput("post_abort_done", 32'(done), 32'd0);
            end
            return;
         end
         @(posedge clk); #1;
         ex = ox + (k % BW);
         ey = oy + (k / BW);
         ep = (ex < SW) && (ey < SH);
         checkOutput("plot_busy",   32'(busy),       32'd1);
         checkOutput("plot_done",   32'(done),       32'd0);
         checkOutput("plot_en",     32'(vga_plot),   32'(ep));
         checkOutput("plot_colour", 32'(vga_colour), 32'(col_exp));
         if (ep) begin
            checkOutput("plot_x", 32'(vga_x), 32'(ex & 255));
            checkOutput("plot_y", 32'(vga_y), 32'(ey & 127));
         end
         if (ignore_at >= 0 && k == ignore_at) begin
            draw = 1'b1;
            x_in = 10'd40;
            y_in = 10'd0;
         end else if (ignore_at >= 0 && k == ignore_at + 1) begin
            draw = 1'b0;
         end
      end
      @(posedge clk); #1;
      checkOutput("done_pulse",  32'(done),       32'd1);
      checkOutput("done_busy",   32'(busy),       32'd1);
      checkOutput("done_plot",   32'(vga_plot),   32'd0);
      checkOutput("done_colour", 32'(vga_colour), 32'd0);
      @(posedge clk); #1;
      checkOutput("after_done",  32'(done),       32'd0);
      checkOutput("after_busy",  32'(busy),       32'd0);
   endtask

   // Directed test-plan bricks followed by random origins, then the summary
   initial begin
      int ox, oy;
      logic [2:0] col;
      logic er;
      compared   = 0;
      mismatched = 0;
      resetn     = 1'b0;
      draw       = 1'b0;
      x_in       = '0;
      y_in       = '0;
      colour_in  = '0;
      erase      = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkIdle("reset");
      resetn = 1'b1;
      @(posedge clk); #1;
      checkIdle("idle");

      $display("[TB] origin (0,0) colour 4");
      applyStimulus(0, 0, 3'b100, 1'b0, 1'b0);
      checkBrick(0, 0, 3'b100, -1, -1);

      $display("[TB] origin (20,10) erase");
      applyStimulus(20, 10, 3'b111, 1'b1, 1'b0);
      checkBrick(20, 10, 3'b000, -1, -1);

      $display("[TB] origin (155,118) partial clip");
      applyStimulus(155, 118, 3'b010, 1'b0, 1'b0);
      checkBrick(155, 118, 3'b010, -1, -1);

      $display("[TB] origin (160,20) fully clipped");
      applyStimulus(160, 20, 3'b101, 1'b0, 1'b0);
      checkBrick(160, 20, 3'b101, -1, -1);

      $display("[TB] stray draw during brick is ignored");
      applyStimulus(7, 3, 3'b001, 1'b0, 1'b0);
      checkBrick(7, 3, 3'b001, 10, -1);
      applyStimulus(40, 0, 3'b110, 1'b0, 1'b0);
      checkBrick(40, 0, 3'b110, -1, -1);

      $display("[TB] reset mid-brick");
      applyStimulus(60, 60, 3'b011, 1'b0, 1'b0);
      checkBrick(60, 60, 3'b011, -1, 25);
      applyStimulus(0, 0, 3'b111, 1'b0, 1'b0);
      checkBrick(0, 0, 3'b111, -1, -1);

      $display("[TB] back-to-back with draw held high");
      applyStimulus(5, 7, 3'b100, 1'b0, 1'b1);
      x_in      = 10'd30;
      y_in      = 10'd50;
      colour_in = 3'b011;
      erase     = 1'b0;
      checkBrick(5, 7, 3'b100, -1, -1);
      draw      = 1'b0;
      checkBrick(30, 50, 3'b011, -1, -1);

      $display("[TB] random origins");
      for (int r = 0; r < 8; r++) begin
         ox  = (r % 2 == 0) ? int'($urandom_range(0, 170)) : int'($urandom_range(0, 1023));
         oy  = (r % 2 == 0) ? int'($urandom_range(0, 125)) : int'($urandom_range(0, 1023));
         col = 3'($urandom);
         er  = 1'($urandom);
         applyStimulus(ox, oy, col, er, 1'b0);
         checkBrick(ox, oy, er ? 3'b000 : col, -1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/brick_pixel_plotter.md
# brick_pixel_plotter

Rasterises one brick per request into single-pixel writes for the VGA adapter. Sits directly downstream of the brick draw sequencer: each `draw` strobe carries a brick origin (`x_in`, `y_in`). The block emits BRICK_W × BRICK_H pixel writes, one per clock, then pulses `done` so the sequencer can advance to the next brick. Pixels outside the screen are suppressed, not wrapped.

## Interface
- BRICK_W, 10: brick width in pixels (≥1).
- BRICK_H, 5: brick height in pixels (≥1).
- SCREEN_W, 160: visible width; pixels with x ≥ SCREEN_W are clipped.
- SCREEN_H, 120: visible height; pixels with y ≥ SCREEN_H are clipped.
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- draw  in  1  request strobe; sampled only in IDLE.
- x_in  in  10  brick origin x (top-left).
- y_in  in  10  brick origin y (top-left).
- colour_in  in  3  brick colour.
- erase  in  1  sampled with `draw`; 1 forces colour 3'b000.
- busy  out  1  high while a request is in progress.
- done  out  1  one-cycle completion pulse.
- vga_x  out  8  pixel x to the adapter.
- vga_y  out  7  pixel y to the adapter.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  write enable for the current pixel.

## Operation
- FSM states: IDLE, PLOT, DONE.
- IDLE + `draw`=1:
  - Latch x_in, y_in, and colour (`erase` ? 0 : colour_in).
  - Clear dx and dy.
  - Go to PLOT.
- IDLE + `draw`=0: stay in IDLE.
- PLOT: each cycle emits pixel (x_base+dx, y_base+dy).
  - dx counts 0..BRICK_W-1. On wrap it returns to 0 and dy increments.
  - Scan order is row-major, top row first.
  - After pixel (BRICK_W-1, BRICK_H-1), go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `draw` in PLOT or DONE is ignored. No queueing: the requester must wait for `done`.
- Arithmetic:
  - px = x_base + dx and py = y_base + dy, computed at 11 bits. No overflow wrap.
  - vga_plot = in_plot_cycle & (px < SCREEN_W) & (py < SCREEN_H).
  - vga_x = px[7:0] and vga_y = py[6:0] are always driven. They are don't-care when vga_plot=0.
- Clipped pixels still consume their cycle. Request length is fixed at BRICK_W·BRICK_H cycles regardless of position.
- vga_colour holds the latched colour throughout PLOT. It is 0 otherwise.

## Timing
- All outputs are registered.
- Reset values: busy=0, done=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0. State is IDLE, counters are 0.
- `draw` sampled at edge N: pixel (0,0) is presented after edge N+1, with busy=1 from that point.
- Pixel k (0-based, row-major) is presented after edge N+1+k. The last pixel is presented after edge N+BRICK_W·BRICK_H.
- `done`=1 after edge N+BRICK_W·BRICK_H+1 for one cycle. busy stays 1 through that cycle and drops on the next edge.
- Default total: 50 plot cycles + 1 done cycle. The earliest next accepted `draw` is sampled at edge N+52.
- Back-to-back: a `draw` held high continuously is accepted on the first IDLE cycle after DONE.
- Reset mid-operation (resetn=0 at any edge):
  - Abort immediately and return to IDLE.
  - All outputs return to reset values on that edge. No `done` pulse is produced.
- `x_in`, `y_in`, `colour_in`, and `erase` may change freely after the accepting edge; latched values are used.

## Test plan
- Origin (0,0), colour 3'b100, erase=0:
  - 50 consecutive plot=1 cycles covering x 0..9 and y 0..4, row-major.
  - Colour is 4 on every pixel.
  - done pulses once, 51 cycles after `draw`.
- Origin (20,10), erase=1, colour_in=3'b111: 50 plots over x 20..29, y 10..14, all with vga_colour=0.
- Origin (155,118): plot=1 only for x 155..159 and y 118..119 (10 pixels). All other cycles have plot=0. done still arrives at cycle 51.
- Origin (160,20): plot=0 on all 50 cycles; busy and done timing unchanged.
- `draw` pulsed again at cycle 10 with origin (40,0): the pulse is ignored and the first brick completes unchanged. A new `draw` after done is accepted at (40,0).
- resetn=0 at cycle 25 of a brick: on that edge busy=0, plot=0, and all outputs are 0. No done pulse. The next `draw` starts a fresh brick from pixel (0,0).
